// File: rtl/booth_mul_iter.sv
// booth_mul_iter
//   Iterative radix-4 Booth multiplier. Operands are sign- or zero-extended
//   to WIDTH+2 bits and accepted once. Each BUSY cycle folds PP_PER_CYCLE
//   Booth partial products into a redundant sum/carry accumulator through
//   3:2 carry-save stages. One final cycle resolves the accumulator with a
//   block carry-lookahead adder. The result is then held until the consumer
//   takes it.
//
//   Optional feature macro: BOOTH_MUL_EARLY_OUT_EN
//     When defined, BUSY ends early once every remaining multiplier bit is
//     equal, because all remaining Booth digits are then zero.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid / in_ready     operand handshake
//     in_x, in_y              multiplicand, multiplier (WIDTH bits)
//     in_x_signed/in_y_signed treat the operand as two's complement
//     flush                   abort any operation in flight
//     out_valid / out_ready   product handshake
//     out_prod                full 2*WIDTH-bit product
module booth_mul_iter #(
   parameter int WIDTH        = 64,
   parameter int PP_PER_CYCLE = 4,
   parameter int CLA_SIZE     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   input  logic                 in_x_signed,
   input  logic                 in_y_signed,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod
);

   localparam int unsigned XW   = WIDTH + 2;
   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned NPP  = WIDTH / 2 + 1;
   localparam int unsigned NCYC = (NPP + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
   localparam int unsigned CW   = $clog2(NCYC + 1);
   localparam int unsigned NGRP = (PW + CLA_SIZE - 1) / CLA_SIZE;

   typedef enum logic [1:0] {IDLE, BUSY, ADD, DONE} state_t;

   state_t          r_state, w_next;
   logic [XW-1:0]   r_x, r_y;
   logic [PW-1:0]   r_sum;
   logic [PW-2:0]   r_carry;      // weight is carry<<1, so the top bit is never needed
   logic [CW-1:0]   r_cnt;
   logic            r_out_valid;
   logic [PW-1:0]   r_prod;

   logic [PW-1:0]   w_xe;
   logic [XW:0]     w_yp;
   logic [PW-1:0]   w_sum, w_op, w_neg;
   logic [PW-2:0]   w_cmaj, w_maj;
   logic [2:0]      w_dig;
   int unsigned     w_dig_idx;
   logic            w_early;
   logic [PW-1:0]   w_ca, w_cb, w_gen, w_prp, w_cin, w_cla;
   logic            w_rg, w_rp, w_gcin;
   int unsigned     w_bi;

   function automatic logic [PW-2:0] f_maj(input logic [PW-2:0] a,
                                           input logic [PW-2:0] b,
                                           input logic [PW-2:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out_prod  = r_prod;

   assign w_xe = {{(PW - XW){r_x[XW-1]}}, r_x};
   assign w_yp = {r_y, 1'b0};    // bit -1 of the multiplier is 0

   // One BUSY step: Booth digits of this cycle plus the deferred +1 terms
   // of negated digits, each folded in through a 3:2 carry-save stage.
   always_comb begin
      w_sum     = r_sum;
      w_cmaj    = r_carry;
      w_neg     = '0;
      w_op      = '0;
      w_dig     = '0;
      w_dig_idx = 0;
      w_maj     = '0;
      for (int unsigned j = 0; j < PP_PER_CYCLE; j++) begin
         w_dig_idx = PP_PER_CYCLE * 32'(r_cnt) + j;
         w_op      = '0;
         if (w_dig_idx < NPP) begin
            w_dig = 3'(w_yp >> (2 * w_dig_idx));
            case (w_dig)
               3'b001, 3'b010: w_op = w_xe;
               3'b011:         w_op = w_xe << 1;
               3'b100: begin
                  w_op = ~(w_xe << 1);
                  w_neg[2 * w_dig_idx] = 1'b1;
               end
               3'b101, 3'b110: begin
                  w_op = ~w_xe;
                  w_neg[2 * w_dig_idx] = 1'b1;
               end
               default:        w_op = '0;
            endcase
            // Inverting before the shift keeps the vacated low bits zero, so
            // the +1 at bit 2i completes the two's-complement negation.
            w_op = w_op << (2 * w_dig_idx);
         end
         w_maj  = f_maj(w_sum[PW-2:0], {w_cmaj[PW-3:0], 1'b0}, w_op[PW-2:0]);
         w_sum  = w_sum ^ {w_cmaj, 1'b0} ^ w_op;
         w_cmaj = w_maj;
      end
      w_maj  = f_maj(w_sum[PW-2:0], {w_cmaj[PW-3:0], 1'b0}, w_neg[PW-2:0]);
      w_sum  = w_sum ^ {w_cmaj, 1'b0} ^ w_neg;
      w_cmaj = w_maj;
   end

   // Block carry-lookahead: running group generate/propagate gives every bit
   // carry from the group carry-in; group carries chain between blocks.
   always_comb begin
      w_ca   = r_sum;
      w_cb   = {r_carry, 1'b0};
      w_gen  = w_ca & w_cb;
      w_prp  = w_ca ^ w_cb;
      w_cin  = '0;
      w_gcin = 1'b0;
      w_rg   = 1'b0;
      w_rp   = 1'b1;
      w_bi   = 0;
      for (int unsigned k = 0; k < NGRP; k++) begin
         w_rg = 1'b0;
         w_rp = 1'b1;
         for (int unsigned b = 0; b < CLA_SIZE; b++) begin
            w_bi = k * CLA_SIZE + b;
            if (w_bi < PW) begin
               w_cin[w_bi] = w_rg | (w_rp & w_gcin);
               w_rg        = w_gen[w_bi] | (w_prp[w_bi] & w_rg);
               w_rp        = w_rp & w_prp[w_bi];
            end
         end
         w_gcin = w_rg | (w_rp & w_gcin);
      end
      w_cla = w_prp ^ w_cin;
   end

`ifdef BOOTH_MUL_EARLY_OUT_EN
   int unsigned w_pos;
   always_comb begin
      w_early = 1'b1;
      w_pos   = 2 * (32'(r_cnt) + 1) * PP_PER_CYCLE - 1;
      for (int unsigned k = 0; k < XW; k++) begin
         if (k >= w_pos && r_y[k] != r_y[XW-1]) w_early = 1'b0;
      end
   end
`else
   assign w_early = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (in_valid) w_next = BUSY;
         BUSY: if (r_cnt == CW'(NCYC - 1) || w_early) w_next = ADD;
         ADD:  w_next = DONE;
         DONE: if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (flush) w_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= '0;
         r_y         <= '0;
         r_sum       <= '0;
         r_carry     <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_prod      <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_x     <= {{2{in_x_signed & in_x[WIDTH-1]}}, in_x};
               r_y     <= {{2{in_y_signed & in_y[WIDTH-1]}}, in_y};
               r_sum   <= '0;
               r_carry <= '0;
               r_cnt   <= '0;
            end
            BUSY: begin
               r_sum   <= w_sum;
               r_carry <= w_cmaj;
               r_cnt   <= r_cnt + 1'b1;
            end
            ADD: begin
               r_prod      <= w_cla;
               r_out_valid <= 1'b1;
            end
            DONE: if (out_ready) r_out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_iter.sv
module tb_booth_mul_iter;

   localparam int W = 64;

`ifdef BOOTH_MUL_EARLY_OUT_EN
   localparam logic [63:0] FY = 64'h8000_0000_0000_0009;
   localparam int LAT79 = 2;
`else
   localparam logic [63:0] FY = 64'd9;
   localparam int LAT79 = 10;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_x = '0;
   logic [W-1:0]     in_y = '0;
   logic             in_x_signed = 1'b0;
   logic             in_y_signed = 1'b0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2*W-1:0]   out_prod;

   always #5 clk = ~clk;

   booth_mul_iter #(.WIDTH(W), .PP_PER_CYCLE(4), .CLA_SIZE(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y),
      .in_x_signed(in_x_signed), .in_y_signed(in_y_signed),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_prod(out_prod)
   );

   typedef struct {
      logic [63:0]  x;
      logic [63:0]  y;
      logic         xs;
      logic         ys;
      logic [127:0] p;
      int           lat_e;   // early-out latency, 0 = only range-checked
   } vec_t;

   vec_t vecs[14];
   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called one time unit after a rising edge; returns one unit after the
   // edge on which out_valid was first seen high.
   task automatic do_mul(input logic [63:0] x, input logic [63:0] y,
                         input logic xs, input logic ys,
                         output logic [127:0] prod, output int lat);
      int w = 0;
      while (!in_ready && w < 30) begin
         @(posedge clk); #1; w++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      in_x = x; in_y = y; in_x_signed = xs; in_y_signed = ys; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_x = {$urandom, $urandom};
      in_y = {$urandom, $urandom};
      in_x_signed = ~xs;
      in_y_signed = ~ys;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      prod = out_prod;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] p;
      int lat;
      int seen;

      vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                   128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 10};
      vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                   128'h1, 2};
      vecs[2]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
                   128'h4000_0000_0000_0000_0000_0000_0000_0000, 0};
      vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b0,
                   128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 2};
      vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b0, 1'b0,
                   128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFFA, 2};
      vecs[5]  = '{64'd7, 64'd9, 1'b0, 1'b0, 128'd63, 2};
      vecs[6]  = '{64'd0, 64'h1234, 1'b1, 1'b0, 128'd0, 0};
      vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0,
                   128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 10};
      vecs[8]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0,
                   128'hC000_0000_0000_0000_0000_0000_0000_0000, 10};
      vecs[9]  = '{64'h1234_5678, 64'h10, 1'b0, 1'b0, 128'h1_2345_6780, 2};
      vecs[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                   128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 0};
      vecs[11] = '{64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                   128'h0000_0000_0000_0000_8000_0000_0000_0000, 10};
      vecs[12] = '{64'd3, 64'd5, 1'b0, 1'b0, 128'd15, 2};
      vecs[13] = '{64'h0123_4567_89AB_CDEF, 64'd2, 1'b1, 1'b1,
                   128'h0246_8ACF_1357_9BDE, 2};

      // reset state
      #12;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_prod", out_prod, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // table-driven products and latency
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         do_mul(vecs[i].x, vecs[i].y, vecs[i].xs, vecs[i].ys, p, lat);
         chk($sformatf("vec%0d_prod", i), p, vecs[i].p);
`ifdef BOOTH_MUL_EARLY_OUT_EN
         if (vecs[i].lat_e != 0) chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat_e);
         else chk($sformatf("vec%0d_latency_range", i), (lat >= 2 && lat <= 10), 1);
`else
         chk($sformatf("vec%0d_latency", i), lat, 10);
`endif
         @(posedge clk); #1;
         chk($sformatf("vec%0d_handshake", i), {out_valid, in_ready}, 2'b01);
      end

      // backpressure
      out_ready = 1'b0;
      do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, p, lat);
      chk("bp_prod", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      chk("bp_latency", lat, 10);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_hold_prod_%0d", c), out_prod,
             128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
         chk($sformatf("bp_hold_ctl_%0d", c), {out_valid, in_ready}, 2'b10);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", {out_valid, in_ready}, 2'b01);

      // flush mid-operation, with in_valid offered during the flush cycle
      in_x = 64'd7; in_y = FY; in_x_signed = 1'b0; in_y_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("flush_accepted", in_ready, 0);
      repeat (3) begin @(posedge clk); #1; end
      flush = 1'b1; in_valid = 1'b1; in_x = 64'd5; in_y = 64'd5;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_in_ready", in_ready, 1);
      seen = 0;
      repeat (15) begin @(posedge clk); #1; if (out_valid) seen = 1; end
      chk("flush_no_output", seen, 0);
      do_mul(64'd7, 64'd9, 1'b0, 1'b0, p, lat);
      chk("after_flush_prod", p, 128'd63);
      chk("after_flush_latency", lat, LAT79);
      @(posedge clk); #1;

      // flush while a product waits, with out_ready raised the same cycle
      out_ready = 1'b0;
      do_mul(64'd7, 64'd9, 1'b0, 1'b0, p, lat);
      chk("done_flush_prod", p, 128'd63);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("done_flush_ctl", {out_valid, in_ready}, 2'b01);

      // asynchronous reset mid-operation
      in_x = 64'd3; in_y = 64'h8000_0000_0000_0000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_prod", out_prod, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (15) begin @(posedge clk); #1; if (out_valid) seen = 1; end
      chk("midrst_no_output", seen, 0);
      do_mul(64'd7, 64'd9, 1'b0, 1'b0, p, lat);
      chk("after_rst_prod", p, 128'd63);
      chk("after_rst_latency", lat, LAT79);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
